// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_pkg
// Purpose  : Shared FSM state type, default geometry and index-width helper
//            for the pixel array readout block.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_pkg;

  localparam int DEF_N_ROWS = 2;
  localparam int DEF_N_COLS = 2;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_LOAD   = 2'd2,
    ST_STREAM = 2'd3
  } state_e;

  // Counter width for n entries; a single entry still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_row_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_row_buffer
// Purpose  : N_COLS-entry pixel row store with parallel load and indexed read.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_row_buffer
  import pixel_pkg::*;
#(
  parameter int N_COLS = DEF_N_COLS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int COL_W  = idx_w(DEF_N_COLS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [N_COLS*DATA_W-1:0] load_data,
  input  logic [COL_W-1:0]         rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  logic [N_COLS*DATA_W-1:0] row_q, row_d;

  always_comb begin
    row_d = row_q;
    if (load) row_d = load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) row_q <= '0;
    else       row_q <= row_d;
  end

  // Compare-based mux keeps the index width independent of N_COLS.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < N_COLS; c++) begin
      if (rd_idx == COL_W'(c)) rd_data = row_q[c*DATA_W +: DATA_W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_array_readout.sv
`default_nettype none
// ============================================================================
// Module   : pixel_array_readout
// Purpose  : Row-by-row pixel array readout to a valid/ready pixel stream
//            with frame/line markers. Optional test pattern source selected
//            by PIXEL_ARRAY_READOUT_TEST_PATTERN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_array_readout
  import pixel_pkg::*;
#(
  parameter int N_ROWS = DEF_N_ROWS,
  parameter int N_COLS = DEF_N_COLS,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [N_COLS*DATA_W-1:0]    row_data,
  output logic [idx_w(N_ROWS)-1:0]    row_ptr,
  output logic                        row_read,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_sof,
  output logic                        out_eol,
  output logic                        out_eof,
  output logic                        busy
);

  localparam int ROW_W = idx_w(N_ROWS);
  localparam int COL_W = idx_w(N_COLS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               valid_q, valid_d;
  logic               sof_q, sof_d;
  logic               eol_q, eol_d;
  logic               eof_q, eof_d;
  logic               busy_q, busy_d;
  logic               rd_q, rd_d;
  logic [N_COLS*DATA_W-1:0] load_data;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    if (state_q != ST_IDLE && abort) begin
      state_d = ST_IDLE;
      row_d   = '0;
      col_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_d = ST_SELECT;
          row_d   = '0;
        end
        ST_SELECT: state_d = ST_LOAD;
        ST_LOAD: begin
          state_d = ST_STREAM;
          col_d   = '0;
        end
        ST_STREAM: if (out_ready) begin
          if (col_q == LAST_COL) begin
            if (row_q == LAST_ROW) begin
              state_d = ST_IDLE;
            end else begin
              row_d   = row_q + ROW_W'(1);
              state_d = ST_SELECT;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered from the next-state view so they change with the state.
    valid_d = (state_d == ST_STREAM);
    sof_d   = valid_d && (row_d == '0) && (col_d == '0);
    eol_d   = valid_d && (col_d == LAST_COL);
    eof_d   = eol_d && (row_d == LAST_ROW);
    busy_d  = (state_d != ST_IDLE);
`ifdef PIXEL_ARRAY_READOUT_TEST_PATTERN_EN
    rd_d    = 1'b0;
`else
    rd_d    = (state_d == ST_SELECT) || (state_d == ST_LOAD);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
    end
  end

`ifdef PIXEL_ARRAY_READOUT_TEST_PATTERN_EN
  always_comb begin
    load_data = '0;
    for (int c = 0; c < N_COLS; c++) begin
      load_data[c*DATA_W +: DATA_W] = DATA_W'(int'(row_q) * N_COLS + c);
    end
  end
`else
  assign load_data = row_data;
`endif

  pixel_row_buffer #(
    .N_COLS (N_COLS),
    .DATA_W (DATA_W),
    .COL_W  (COL_W)
  ) u_row_buffer (
    .clk       (clk),
    .reset     (reset),
    .load      (state_q == ST_LOAD),
    .load_data (load_data),
    .rd_idx    (col_q),
    .rd_data   (out_data)
  );

  assign row_ptr   = row_q;
  assign row_read  = rd_q;
  assign out_valid = valid_q;
  assign out_sof   = sof_q;
  assign out_eol   = eol_q;
  assign out_eof   = eof_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/pixel_array_readout.md
PIXEL_ARRAY_READOUT -- requirements
Module: pixel_array_readout

Interface
REQ-001 SHALL have parameter N_ROWS, default 2, number of pixel rows (>=1).
REQ-002 SHALL have parameter N_COLS, default 2, number of pixel columns (>=1).
REQ-003 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request one frame readout; sampled in IDLE only.
REQ-007 SHALL have port abort  input  1  terminate the current frame.
REQ-008 SHALL have port row_data  input  N_COLS*DATA_W  selected row from the array; column c at bits [c*DATA_W +: DATA_W].
REQ-009 SHALL have port row_ptr  output  max(1,clog2(N_ROWS))  row select driven to the array.
REQ-010 SHALL have port row_read  output  1  high while the array drives row_data for row_ptr.
REQ-011 SHALL have port out_data  output  DATA_W  pixel value.
REQ-012 SHALL have port out_valid  output  1  out_data holds a valid pixel.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the pixel.
REQ-014 SHALL have port out_sof / out_eol / out_eof  output  1 each  first pixel of frame / last of row / last of frame; qualified by out_valid.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SELECT, LOAD, STREAM.
REQ-017 IDLE -> SELECT when start=1; row counter := 0.
REQ-018 SELECT: drive row_ptr=row counter, row_read=1; next state LOAD (one settle cycle).
REQ-019 LOAD: keep row_ptr and row_read=1; capture row_data into an N_COLS-entry row buffer; column counter := 0; next state STREAM.
REQ-020 STREAM: out_valid=1, out_data=buffer[column counter]; row_read=0.
REQ-021 Transfer occurs when out_valid & out_ready; only then does the column counter advance.
REQ-022 While out_valid=1 and out_ready=0, out_data and all flags SHALL stay stable.
REQ-023 On transfer of column N_COLS-1: row < N_ROWS-1 -> row+1, go to SELECT; otherwise go to IDLE.
REQ-024 out_sof=1 only for row 0 / column 0. out_eol=1 for column N_COLS-1. out_eof=1 for row N_ROWS-1 / column N_COLS-1. With N_COLS=1 or N_ROWS=1, flags coincide on the same beat.
REQ-025 Latency: start at cycle t gives the first out_valid at t+3. Each row boundary costs 2 bubble cycles.
REQ-026 start outside IDLE SHALL be ignored. start coincident with the final transfer SHALL NOT be accepted until IDLE.
REQ-027 abort in any non-IDLE state -> IDLE next cycle; out_valid=0 from that cycle; no out_eof is emitted. abort has priority over transfer.
REQ-028 Counters SHALL never exceed N_ROWS-1 / N_COLS-1. There is no wrap-around within a frame.

Reset
REQ-029 reset=1 SHALL force state IDLE and clear both counters and the row buffer to 0.
REQ-030 Reset values SHALL be: row_ptr=0, row_read=0, out_data=0, out_valid=0, out_sof/eol/eof=0, busy=0.
REQ-031 reset SHALL override start and abort. Reset mid-frame SHALL discard the frame with no further output.

Configuration
REQ-032 Macro PIXEL_ARRAY_READOUT_TEST_PATTERN_EN defined: LOAD SHALL capture row*N_COLS+col (truncated to DATA_W) instead of row_data, and row_read SHALL stay 0.
REQ-033 Macro undefined: the test-pattern logic SHALL be absent and row_data SHALL be used.

Structure
REQ-034 A shared package pixel_pkg SHALL hold the FSM state enum typedef and the default N_ROWS/N_COLS/DATA_W constants.
REQ-035 The row buffer (parallel load, indexed read) SHALL be a sub-module named pixel_row_buffer. The FSM and counters SHALL stay in the top module.

Verification
REQ-036 N_ROWS=2, N_COLS=2, DATA_W=8, rows {0x10,0x11},{0x20,0x21}, out_ready=1, start pulse -> outputs 0x10(sof),0x11(eol),0x20,0x21(eol,eof); first valid at start+3; busy low after.
REQ-037 Same setup, out_ready=0 for 5 cycles at the 0x11 beat -> 0x11 and its flags held stable for 5 cycles, with no pixel loss or duplication.
REQ-038 abort during the 0x20 beat -> next cycle out_valid=0, busy=0, no eof; a new start then replays the full frame from 0x10.
REQ-039 reset asserted mid-row-1 -> all outputs at reset values next cycle; start during busy is ignored (pixel count remains 4).
REQ-040 N_ROWS=4, N_COLS=1, with PIXEL_ARRAY_READOUT_TEST_PATTERN_EN -> outputs 0,1,2,3, each with eol; eof on 3; row_read stays 0.
